// File: rtl/spi_write_controller.sv
// spi_write_controller
//   SPI mode-0 initiator that sends one 16-bit {rw, addr[6:0], data[7:0]}
//   register-write frame per accepted request, MSB first.
//
// Ports
//   clk, rst                 system clock, synchronous active-high reset
//   req_valid / req_ready    request handshake; accepted when both are high
//   req_rw, req_addr,        frame bit 15, bits 14:8, bits 7:0
//   req_data
//   busy                     transaction in progress
//   done                     one-cycle pulse in the last cycle of a frame
//   sclk, copi, ncs          SPI bus (CPOL=0, CPHA=0, ncs active-low)
//
// Every phase (LEAD, each HIGH/LOW half-period, TRAIL, GAP) lasts CLK_DIV
// cycles. All outputs are registered from the next-state values, so each
// output changes in the same cycle the new phase begins.
module spi_write_controller #(
  parameter int CLK_DIV = 4  // clk cycles per sclk half-period, 1..255
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic       req_rw,
  input  logic [6:0] req_addr,
  input  logic [7:0] req_data,
  output logic       busy,
  output logic       done,
  output logic       sclk,
  output logic       copi,
  output logic       ncs
);

  localparam logic [7:0] DIV_M1 = 8'(CLK_DIV - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_LEAD, S_HIGH, S_LOW, S_TRAIL, S_GAP
  } state_t;

  state_t      r_state, w_state_n;
  logic [7:0]  r_cnt,   w_cnt_n;
  logic [3:0]  r_bit,   w_bit_n;
  // Bits still to be sent after the one currently on copi.
  logic [14:0] r_rem,   w_rem_n;
  logic        w_copi_n;
  logic        w_end;

  assign w_end = (r_cnt == DIV_M1);

  always_comb begin
    w_state_n = r_state;
    w_cnt_n   = r_cnt;
    w_bit_n   = r_bit;
    w_rem_n   = r_rem;
    w_copi_n  = copi;

    // Half-period counter runs in every non-IDLE state and wraps at the
    // phase boundary; it is 0 on entry to IDLE so nothing to do there.
    if (r_state != S_IDLE)
      w_cnt_n = w_end ? 8'd0 : r_cnt + 8'd1;

    case (r_state)
      S_IDLE: begin
        if (req_valid && req_ready) begin
          w_state_n = S_LEAD;
          w_copi_n  = req_rw;
          w_rem_n   = {req_addr, req_data};
          w_bit_n   = 4'd15;
          w_cnt_n   = 8'd0;
        end
      end
      S_LEAD:  if (w_end) w_state_n = S_HIGH;
      S_HIGH: begin
        if (w_end) begin
          if (r_bit == 4'd0) begin
            w_state_n = S_TRAIL;
          end else begin
            // Falling edge: present the next bit in the first LOW cycle.
            w_state_n = S_LOW;
            w_copi_n  = r_rem[14];
            w_rem_n   = {r_rem[13:0], 1'b0};
            w_bit_n   = r_bit - 4'd1;
          end
        end
      end
      S_LOW:   if (w_end) w_state_n = S_HIGH;
      S_TRAIL: begin
        if (w_end) begin
          w_state_n = S_GAP;
          w_copi_n  = 1'b0;
        end
      end
      S_GAP:   if (w_end) w_state_n = S_IDLE;
      default: begin
        w_state_n = S_IDLE;
        w_cnt_n   = 8'd0;
        w_copi_n  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_cnt     <= 8'd0;
      r_bit     <= 4'd0;
      r_rem     <= 15'd0;
      req_ready <= 1'b1;
      busy      <= 1'b0;
      done      <= 1'b0;
      sclk      <= 1'b0;
      copi      <= 1'b0;
      ncs       <= 1'b1;
    end else begin
      r_state   <= w_state_n;
      r_cnt     <= w_cnt_n;
      r_bit     <= w_bit_n;
      r_rem     <= w_rem_n;
      copi      <= w_copi_n;
      req_ready <= (w_state_n == S_IDLE);
      busy      <= (w_state_n != S_IDLE);
      sclk      <= (w_state_n == S_HIGH);
      ncs       <= !(w_state_n inside {S_LEAD, S_HIGH, S_LOW, S_TRAIL});
      // Last GAP cycle: the counter value being loaded is the terminal one.
      done      <= (w_state_n == S_GAP) && (w_cnt_n == DIV_M1);
    end
  end

endmodule

// File: tb/tb_spi_write_controller.sv
// Directed bench for spi_write_controller: one instance with CLK_DIV=4 and
// one with CLK_DIV=1. Frames are captured on sclk rising edges and compared
// against hand-written frame constants and cycle offsets from the accept cycle.
module tb_spi_write_controller;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [1:0] vld, rw, rdy, bsy, dn, sck, co, cs;
  logic [6:0] addr [2];
  logic [7:0] data [2];

  int errs   = 0;
  int checks = 0;
  int cyc    = 0;
  always @(posedge clk) cyc <= cyc + 1;

  spi_write_controller #(.CLK_DIV(4)) u_a (
    .clk(clk), .rst(rst), .req_valid(vld[0]), .req_ready(rdy[0]),
    .req_rw(rw[0]), .req_addr(addr[0]), .req_data(data[0]),
    .busy(bsy[0]), .done(dn[0]), .sclk(sck[0]), .copi(co[0]), .ncs(cs[0])
  );

  spi_write_controller #(.CLK_DIV(1)) u_b (
    .clk(clk), .rst(rst), .req_valid(vld[1]), .req_ready(rdy[1]),
    .req_rw(rw[1]), .req_addr(addr[1]), .req_data(data[1]),
    .busy(bsy[1]), .done(dn[1]), .sclk(sck[1]), .copi(co[1]), .ncs(cs[1])
  );

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Bus invariants on every cycle, plus ncs-high run length and done count.
  int viol_cs [2] = '{0, 0};
  int viol_co [2] = '{0, 0};
  int hirun   [2] = '{0, 0};
  int lastgap [2] = '{0, 0};
  int dcount  [2] = '{0, 0};
  logic [1:0] pco = 2'b00;

  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (cs[k] && sck[k]) viol_cs[k] <= viol_cs[k] + 1;
      if (sck[k] && (co[k] !== pco[k])) viol_co[k] <= viol_co[k] + 1;
      pco[k] <= co[k];
      if (cs[k] === 1'b1) hirun[k] <= hirun[k] + 1;
      else if (cs[k] === 1'b0 && hirun[k] != 0) begin
        lastgap[k] <= hirun[k];
        hirun[k]   <= 0;
      end
      if (dn[k] === 1'b1) dcount[k] <= dcount[k] + 1;
    end
  end

  // Present a request and wait until it is seen with req_ready high;
  // t0 is the stamp of the accept cycle.
  task automatic req(input int k, input logic [15:0] f, output int t0);
    rw[k]   = f[15];
    addr[k] = f[14:8];
    data[k] = f[7:0];
    vld[k]  = 1'b1;
    t0 = -1;
    for (int n = 0; n < 400; n++) begin
      @(negedge clk);
      if (rdy[k]) begin
        t0 = cyc;
        break;
      end
    end
    if (t0 < 0) chk("accept_timeout", 0, 1);
  endtask

  // Follow one frame from the accept edge to return to IDLE.
  // mode 0: plain; 1: keep valid high with payload nxt for a back-to-back
  // frame; 2: change payload every cycle while busy; 3: reset after the 7th
  // rising edge.
  task automatic walk(input int k, input int t0, input logic [15:0] f,
                      input int mode, input logic [15:0] nxt, output int tnext);
    int div = (k == 0) ? 4 : 1;
    logic [15:0] cap = 16'h0;
    int redge = 0, low = 0, frise = -1, flow = -1, llow = -1, dcyc = -1, rdyhi = 0;
    logic ps = 1'b0;
    tnext = -1;
    @(posedge clk); #1;
    if (mode == 1) begin
      rw[k] = nxt[15]; addr[k] = nxt[14:8]; data[k] = nxt[7:0];
    end else if (mode != 2) begin
      vld[k] = 1'b0;
    end
    for (int n = 0; n < 40 * div + 4 && dcyc < 0; n++) begin
      @(negedge clk);
      if (rdy[k]) rdyhi++;
      if (!cs[k]) begin
        low++;
        if (flow < 0) flow = cyc;
        llow = cyc;
      end
      if (sck[k] && !ps) begin
        cap = {cap[14:0], co[k]};
        redge++;
        if (frise < 0) frise = cyc;
      end
      ps = sck[k];
      if (dn[k]) dcyc = cyc;
      if (mode == 2) begin
        if (dn[k]) vld[k] = 1'b0;
        else begin
          rw[k] = 1'($urandom); addr[k] = 7'($urandom); data[k] = 8'($urandom);
        end
      end
      if (mode == 3 && redge == 7) begin
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("rst_ncs",   cs[k],  1);
        chk("rst_sclk",  sck[k], 0);
        chk("rst_copi",  co[k],  0);
        chk("rst_done",  dn[k],  0);
        chk("rst_ready", rdy[k], 1);
        return;
      end
    end
    chk("done_time",  dcyc - t0,  34 * div);
    chk("frame",      cap,        f);
    chk("rise_count", redge,      16);
    chk("first_rise", frise - t0, div + 1);
    chk("ncs_first",  flow - t0,  1);
    chk("ncs_last",   llow - t0,  33 * div);
    chk("ncs_cycles", low,        33 * div);
    chk("ready_busy", rdyhi,      0);
    @(negedge clk);
    chk("ready_back", rdy[k], 1);
    chk("busy_back",  bsy[k], 0);
    tnext = cyc;
  endtask

  initial begin
    int t0, tn, d0;
    rst = 1'b1;
    vld = 2'b00; rw = 2'b00;
    addr[0] = 7'h0; addr[1] = 7'h0; data[0] = 8'h0; data[1] = 8'h0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_ready", rdy, 2'b11);
    chk("reset_busy",  bsy, 2'b00);
    chk("reset_done",  dn,  2'b00);
    chk("reset_sclk",  sck, 2'b00);
    chk("reset_copi",  co,  2'b00);
    chk("reset_ncs",   cs,  2'b11);
    @(posedge clk); #1;
    rst = 1'b0;

    // Single write, CLK_DIV=4
    req(0, 16'h80F0, t0);
    walk(0, t0, 16'h80F0, 0, 16'h0, tn);

    // Back-to-back with valid held through the done cycle
    repeat (3) @(posedge clk); #1;
    d0 = dcount[0];
    req(0, 16'h8480, t0);
    walk(0, t0, 16'h8480, 1, 16'h82FF, tn);
    walk(0, tn, 16'h82FF, 0, 16'h0, tn);
    repeat (4) @(posedge clk); #1;
    chk("gap_ge5",  32'(lastgap[0] >= 5), 1);
    chk("two_done", dcount[0] - d0, 2);

    // Noisy request inputs while busy
    req(0, 16'h8311, t0);
    walk(0, t0, 16'h8311, 2, 16'h0, tn);
    repeat (10) @(negedge clk);
    chk("noise_idle_busy", bsy[0], 0);
    chk("noise_idle_ncs",  cs[0],  1);

    // Reset mid-frame, then a clean frame
    @(posedge clk); #1;
    d0 = dcount[0];
    req(0, 16'h80AA, t0);
    walk(0, t0, 16'h80AA, 3, 16'h0, tn);
    vld[0] = 1'b0;
    repeat (50) @(negedge clk);
    chk("rst_no_done", dcount[0] - d0, 0);
    @(posedge clk); #1;
    req(0, 16'h8155, t0);
    walk(0, t0, 16'h8155, 0, 16'h0, tn);

    // Read frame, CLK_DIV=1
    @(posedge clk); #1;
    req(1, 16'h2A55, t0);
    walk(1, t0, 16'h2A55, 0, 16'h0, tn);

    repeat (3) @(posedge clk); #1;
    chk("inv_sclk_ncs_a", viol_cs[0], 0);
    chk("inv_sclk_ncs_b", viol_cs[1], 0);
    chk("inv_copi_a",     viol_co[0], 0);
    chk("inv_copi_b",     viol_co[1], 0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule

// File: doc/spi_write_controller.md
Name: spi_write_controller

Overview:
- SPI controller (initiator) that generates the 16-bit register-write frames consumed by the chip's SPI register peripheral, which drives the PWM enable and duty-cycle registers.
- Accepts one {rw, addr, data} request via valid/ready and serialises it on sclk/copi/ncs.
- SPI mode 0 (CPOL=0, CPHA=0), MSB first.
- Used as an on-chip test driver and in the system bench to program the PWM register map.

Parameters:
- CLK_DIV, 4, system clk cycles per sclk half-period; legal range 1..255.

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous reset, active-high
- req_valid  input  1  request present
- req_ready  output  1  controller can accept a request
- req_rw  input  1  frame bit 15; 1=write, 0=read (the peripheral ignores reads)
- req_addr  input  7  register address, frame bits 14:8
- req_data  input  8  write data, frame bits 7:0
- busy  output  1  transaction in progress (state != IDLE)
- done  output  1  one-cycle pulse at end of transaction
- sclk  output  1  SPI clock
- copi  output  1  SPI controller-out data
- ncs  output  1  SPI chip select, active-low

Behaviour:
- Clocking: one clock, clk. Reset rst is synchronous and active-high. All outputs are registered.
- Reset values: req_ready=1, busy=0, done=0, sclk=0, copi=0, ncs=1. State is IDLE and the counters are 0.
- Accept: a request is accepted in cycle T0 when req_valid && req_ready. The frame {req_rw, req_addr, req_data} is latched into a 16-bit shift register.
- From T0+1 until return to IDLE: req_ready=0 and busy=1. req_valid is ignored and the request inputs may change freely.
- States: IDLE -> LEAD -> HIGH/LOW alternating (16 HIGH, 15 LOW) -> TRAIL -> GAP -> IDLE. Each non-IDLE state lasts exactly CLK_DIV cycles, timed by a half-period counter.
- LEAD: ncs=0, sclk=0, copi=frame[15].
- HIGH: sclk=1, copi held stable. The peripheral samples on the sclk rising edge, which is the first HIGH cycle.
- LOW: sclk=0. copi updates to the next bit in the first LOW cycle, i.e. on the sclk falling edge.
- Bit counter: counts 15 down to 0. After the HIGH phase of bit 0, go to TRAIL instead of LOW.
- TRAIL: ncs=0, sclk=0, copi holds bit 0.
- GAP: ncs=1, sclk=0, copi=0. done=1 in the last GAP cycle only.
- Return: IDLE with req_ready=1 at T0+34*CLK_DIV+1.
- Timing summary:
  - First sclk rising edge at T0+CLK_DIV+1.
  - Exactly 16 rising edges per frame; sclk period 2*CLK_DIV.
  - ncs low for cycles T0+1 .. T0+33*CLK_DIV inclusive.
  - done asserted at T0+34*CLK_DIV.
- sclk is 0 whenever ncs=1. ncs never glitches within a frame.
- Back-to-back: a request held valid during the done cycle is not accepted in that cycle. It is accepted in the first IDLE cycle, which guarantees at least CLK_DIV+1 cycles of ncs high between frames.
- Reset mid-transaction: on the cycle after rst is sampled high, ncs=1, sclk=0, copi=0, done=0 and the state is IDLE. The partial frame is abandoned and no done pulse is issued.
- rst overrides an accept in the same cycle; the request is not latched.
- No address filtering: any 7-bit address is sent as given. Valid PWM register addresses are 0x00–0x04.

Test Plan:
- Write rw=1, addr=0x00, data=0xF0, CLK_DIV=4 -> copi sampled on 16 sclk rising edges = 0x80F0 MSB first; ncs low 132 cycles; done at T0+136; req_ready high at T0+137.
- Write addr=0x04, data=0x80, then immediately (valid held) addr=0x02, data=0xFF -> two frames 0x8480 and 0x82FF; ncs high at least 5 cycles between them; exactly two done pulses.
- Assert req_valid with a different payload every cycle while busy -> no second frame starts; the frame in flight is unchanged; req_ready stays 0 until return to IDLE.
- rst asserted after the 7th sclk rising edge -> next cycle ncs=1, sclk=0, copi=0; no done pulse; a new request 0x8155 then completes correctly.
- CLK_DIV=1, rw=0, addr=0x2A, data=0x55 -> frame 0x2A55; sclk toggles every cycle; done at T0+34; ncs low cycles T0+1..T0+33.
- Checker on every cycle of every test -> sclk=0 whenever ncs=1; copi changes only while sclk=0.
